// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared state encoding, burst geometry and way decode for the icache refill path
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } refill_state_t;

    localparam int WAYS = 2;

    function automatic int beats_of(input int line_bits, input int beat_bits);
        return line_bits / beat_bits;
    endfunction

    function automatic int cnt_width_of(input int beats);
        return $clog2(beats);
    endfunction

    function automatic logic [WAYS-1:0] way_onehot(input logic sel);
        logic [WAYS-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/refill_line_buf.sv
// rtl/refill_line_buf.sv - beat-slot assembler that builds one cache line from narrow memory beats
module refill_line_buf
    import icache_pkg::*;
#(
    parameter int data_width = 128,
    parameter int beat_width = 32,
    parameter int cnt_w      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [cnt_w-1:0]      wr_slot,
    input  logic [beat_width-1:0] wr_data,
    output logic [data_width-1:0] line
);

    logic [data_width-1:0] line_q;

    // line includes the beat being written this cycle so the final beat can be captured in the same edge
    always_comb begin
        line = line_q;
        if (wr_en) begin
            line[int'(wr_slot) * beat_width +: beat_width] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else if (clr) begin
            line_q <= '0;
        end else begin
            line_q <= line;
        end
    end

endmodule

// File: rtl/icache_refill_writer.sv
// rtl/icache_refill_writer.sv - collects a refill burst and writes the assembled line into the chosen way
module icache_refill_writer
    import icache_pkg::*;
#(
    parameter int addr_width = 4,
    parameter int data_width = 128,
    parameter int beat_width = 32,
    parameter int way        = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [addr_width-1:0] req_index,
    input  logic                  req_way,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    input  logic [beat_width-1:0] mem_rdata,
    input  logic                  mem_rlast,
    output logic [data_width-1:0] Data_din_write,
    output logic [addr_width-1:0] Data_addr_write,
    output logic [way-1:0]        Data_we,
    output logic                  done_valid,
    output logic                  err
);

    localparam int BEATS = beats_of(data_width, beat_width);
    localparam int CNT_W = cnt_width_of(BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    refill_state_t         state;
    refill_state_t         state_n;
    logic [CNT_W-1:0]      cnt;
    logic [addr_width-1:0] idx_q;
    logic                  way_q;
    logic                  req_hs;
    logic                  beat_acc;
    logic                  beat_final;
    logic [data_width-1:0] line_full;
    logic [WAYS-1:0]       we_dec;

    assign req_hs     = (state == ST_IDLE) && req_valid;
    assign beat_acc   = (state == ST_FILL) && mem_rvalid;
    assign beat_final = beat_acc && (cnt == CNT_LAST);

    assign req_ready  = (state == ST_IDLE);
    assign mem_rready = (state == ST_FILL);
    assign done_valid = (state == ST_WRITE);
    assign we_dec     = way_onehot(way_q);
    assign Data_we    = (state == ST_WRITE) ? we_dec[way-1:0] : '0;

    refill_line_buf #(
        .data_width (data_width),
        .beat_width (beat_width),
        .cnt_w      (CNT_W)
    ) u_line_buf (
        .clk     (clk),
        .rst     (rstn),
        .clr     (req_hs),
        .wr_en   (beat_acc),
        .wr_slot (cnt),
        .wr_data (mem_rdata),
        .line    (line_full)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_n = ST_FILL;
                end
            end
            ST_FILL: begin
                if (beat_final) begin
                    state_n = ST_WRITE;
                end else if (beat_acc && mem_rlast) begin
                    state_n = ST_IDLE;
                end
            end
            ST_WRITE: state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Write-port data and index are captured with the final beat so they stay stable outside WRITE
    always_ff @(posedge clk) begin
        if (rstn) begin
            cnt             <= '0;
            idx_q           <= '0;
            way_q           <= 1'b0;
            err             <= 1'b0;
            Data_din_write  <= '0;
            Data_addr_write <= '0;
        end else begin
            err <= 1'b0;
            if (req_hs) begin
                idx_q <= req_index;
                way_q <= req_way;
                cnt   <= '0;
            end
            if (beat_acc) begin
                cnt <= cnt + 1'b1;
                if (beat_final) begin
                    Data_din_write  <= line_full;
                    Data_addr_write <= idx_q;
                    err             <= !mem_rlast;
                end else if (mem_rlast) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_refill_writer.sv
// tb/tb_icache_refill_writer.sv - directed scoreboard bench for the icache refill write engine
module tb_icache_refill_writer;

    logic         clk = 1'b0;
    logic         rstn;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_index;
    logic         req_way;
    logic         mem_rvalid;
    logic         mem_rready;
    logic [31:0]  mem_rdata;
    logic         mem_rlast;
    logic [127:0] Data_din_write;
    logic [3:0]   Data_addr_write;
    logic [1:0]   Data_we;
    logic         done_valid;
    logic         err;

    typedef struct {
        logic [1:0]   we;
        logic [3:0]   addr;
        logic [127:0] din;
        logic         done;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;

    localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE_B = 128'hdeadbeef_cafef00d_0badc0de_12345678;
    localparam logic [127:0] LINE_C = 128'h0f0f0f0f_a5a5a5a5_5a5a5a5a_f0f0f0f0;
    localparam logic [127:0] LINE_D = 128'h99990000_88880000_77770000_66660000;

    icache_refill_writer #(
        .addr_width (4),
        .data_width (128),
        .beat_width (32),
        .way        (2)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_index       (req_index),
        .req_way         (req_way),
        .mem_rvalid      (mem_rvalid),
        .mem_rready      (mem_rready),
        .mem_rdata       (mem_rdata),
        .mem_rlast       (mem_rlast),
        .Data_din_write  (Data_din_write),
        .Data_addr_write (Data_addr_write),
        .Data_we         (Data_we),
        .done_valid      (done_valid),
        .err             (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] we, input logic [3:0] addr, input logic [127:0] din,
                            input logic done, input logic e);
        exp_t x;
        x.we = we; x.addr = addr; x.din = din; x.done = done; x.err = e;
        sb.push_back(x);
    endtask

    task automatic request(input logic [3:0] idx, input logic w);
        req_valid = 1'b1;
        req_index = idx;
        req_way   = w;
        chk("req_ready_before_hs", 128'(req_ready), 128'(1'b1));
        tick();
        req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        mem_rlast  = last;
        tick();
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
    endtask

    task automatic send_line(input logic [127:0] line, input logic last_on_final);
        for (int i = 0; i < 4; i++) begin
            send_beat(line[i*32 +: 32], (i == 3) && last_on_final);
        end
    endtask

    // Any write, done or error cycle must match the oldest expected event
    always @(negedge clk) begin
        if (mon_en && (Data_we !== 2'b00 || done_valid !== 1'b0 || err !== 1'b0)) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_event: observed we=%0h done=%0b err=%0b expected none", Data_we, done_valid, err);
            end
            if (sb.size() != 0) begin
                exp_t x;
                x = sb.pop_front();
                chk("ev_we", 128'(Data_we), 128'(x.we));
                chk("ev_done", 128'(done_valid), 128'(x.done));
                chk("ev_err", 128'(err), 128'(x.err));
                if (x.we != 2'b00) begin
                    chk("ev_addr", 128'(Data_addr_write), 128'(x.addr));
                    chk("ev_din", Data_din_write, x.din);
                end
            end
        end
    end

    initial begin
        rstn       = 1'b1;
        req_valid  = 1'b0;
        req_index  = '0;
        req_way    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_rlast  = 1'b0;
        repeat (3) tick();
        rstn = 1'b0;

        chk("rst_req_ready", 128'(req_ready), 128'(1'b1));
        chk("rst_mem_rready", 128'(mem_rready), 128'(1'b0));
        chk("rst_we", 128'(Data_we), 128'(2'b00));
        chk("rst_done", 128'(done_valid), 128'(1'b0));
        chk("rst_err", 128'(err), 128'(1'b0));
        chk("rst_din", Data_din_write, 128'h0);
        chk("rst_addr", 128'(Data_addr_write), 128'h0);
        mon_en = 1'b1;

        // basic refill into way 1
        push_exp(2'b10, 4'h5, LINE_A, 1'b1, 1'b0);
        request(4'h5, 1'b1);
        chk("basic_rready", 128'(mem_rready), 128'(1'b1));
        send_line(LINE_A, 1'b1);
        chk("basic_write_cycle", 128'(Data_we), 128'(2'b10));
        tick();
        chk("basic_ready_again", 128'(req_ready), 128'(1'b1));

        // stalled burst into way 0; idle beat afterwards must not be consumed
        push_exp(2'b01, 4'h5, LINE_A, 1'b1, 1'b0);
        request(4'h5, 1'b0);
        send_beat(LINE_A[31:0], 1'b0);
        repeat (3) begin
            chk("stall_rready", 128'(mem_rready), 128'(1'b1));
            tick();
        end
        send_beat(LINE_A[63:32], 1'b0);
        send_beat(LINE_A[95:64], 1'b0);
        send_beat(LINE_A[127:96], 1'b1);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hbad0bad0;
        chk("idle_rready", 128'(mem_rready), 128'(1'b0));
        tick();
        mem_rvalid = 1'b0;
        chk("idle_still_ready", 128'(req_ready), 128'(1'b1));

        // early last on beat 2
        push_exp(2'b00, 4'h0, 128'h0, 1'b0, 1'b1);
        request(4'h3, 1'b0);
        send_beat(32'h01010101, 1'b0);
        send_beat(32'h02020202, 1'b1);
        chk("early_err", 128'(err), 128'(1'b1));
        chk("early_ready", 128'(req_ready), 128'(1'b1));
        chk("early_no_we", 128'(Data_we), 128'(2'b00));
        tick();
        chk("early_err_pulse", 128'(err), 128'(1'b0));
        chk("early_din_held", Data_din_write, LINE_A);

        // missing last: written, with err alongside done
        push_exp(2'b10, 4'h9, LINE_B, 1'b1, 1'b1);
        request(4'h9, 1'b1);
        send_line(LINE_B, 1'b0);
        tick();
        chk("missing_err_cleared", 128'(err), 128'(1'b0));

        // reset mid-fill with a beat presented during reset
        request(4'h7, 1'b0);
        send_beat(32'haaaaaaaa, 1'b0);
        rstn       = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hbbbbbbbb;
        tick();
        rstn       = 1'b0;
        mem_rvalid = 1'b0;
        chk("midrst_ready", 128'(req_ready), 128'(1'b1));
        chk("midrst_din", Data_din_write, 128'h0);
        chk("midrst_addr", 128'(Data_addr_write), 128'h0);
        tick();
        push_exp(2'b01, 4'h7, LINE_C, 1'b1, 1'b0);
        request(4'h7, 1'b0);
        send_line(LINE_C, 1'b1);
        tick();

        // back-to-back requests with req_valid held
        push_exp(2'b01, 4'h2, LINE_D, 1'b1, 1'b0);
        push_exp(2'b10, 4'hc, LINE_B, 1'b1, 1'b0);
        req_valid = 1'b1;
        req_index = 4'h2;
        req_way   = 1'b0;
        chk("b2b_first_ready", 128'(req_ready), 128'(1'b1));
        tick();
        req_index = 4'hc;
        req_way   = 1'b1;
        chk("b2b_held_off", 128'(req_ready), 128'(1'b0));
        send_line(LINE_D, 1'b1);
        req_valid = 1'b1;
        chk("b2b_write_not_ready", 128'(req_ready), 128'(1'b0));
        tick();
        chk("b2b_second_ready", 128'(req_ready), 128'(1'b1));
        tick();
        req_valid = 1'b0;
        chk("b2b_second_taken", 128'(mem_rready), 128'(1'b1));
        send_line(LINE_B, 1'b1);
        repeat (3) tick();

        chk("sb_drained", 128'(sb.size()), 128'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_refill_writer.md
# icache_refill_writer

Refill-side write engine for the two-way instruction-cache data array. On a miss it accepts a refill request (set index plus victim way), collects the line from the memory read channel as a burst of narrow beats, assembles it into one full cache line and then writes that line into the selected way in a single cycle. It drives the data array's write port (`Data_din_write` / `Data_addr_write` / `Data_we`) and signals completion to the miss-handling logic.

## Interface
Parameters:
- `addr_width`, 4, set-index width; matches the data array address width.
- `data_width`, 128, cache line width in bits.
- `beat_width`, 32, memory read beat width; `data_width/beat_width` (BEATS) is a power of two ≥ 2.
- `way`, 2, number of ways; `Data_we` has one bit per way.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rstn`  in  1  reset, synchronous and active-high (1 = reset).
- `req_valid`  in  1  refill request present.
- `req_ready`  out  1  engine idle; a request is accepted when `req_valid && req_ready`.
- `req_index`  in  addr_width  set index to refill.
- `req_way`  in  1  victim way (0 or 1).
- `mem_rvalid`  in  1  memory beat valid.
- `mem_rready`  out  1  engine accepts beats.
- `mem_rdata`  in  beat_width  beat payload.
- `mem_rlast`  in  1  final beat of burst.
- `Data_din_write`  out  data_width  assembled line.
- `Data_addr_write`  out  addr_width  write index.
- `Data_we`  out  way  one-hot way write enable.
- `done_valid`  out  1  one-cycle pulse: line written.
- `err`  out  1  one-cycle pulse: burst-length violation.

## Operation
- FSM states are IDLE, FILL and WRITE.
- **IDLE:** `req_ready=1`, `mem_rready=0`. On handshake, latch `req_index` and `req_way`, clear the beat counter, and go to FILL.
- **FILL:** `req_ready=0`, `mem_rready=1`. On `mem_rvalid`, store the beat at slice `[cnt*beat_width +: beat_width]`; beat 0 occupies the LSBs. Then increment `cnt`, which is `$clog2(BEATS)` bits wide.
  - If the beat with `cnt==BEATS-1` is accepted, go to WRITE.
  - If `mem_rlast=1` arrives with `cnt<BEATS-1` (early last), pulse `err` and return to IDLE. No array write is made and `done_valid` stays 0.
- **WRITE** lasts one cycle:
  - `Data_we[latched_way]=1` (one-hot) and `Data_addr_write=latched_index`.
  - `Data_din_write` carries the full buffer.
  - `done_valid=1`.
  - If the final beat carried `mem_rlast=0` (missing last), also pulse `err`; the line is still written.
  - Next state is IDLE.
- `Data_we` is 0 in every state except WRITE. `Data_din_write` and `Data_addr_write` hold their last values outside WRITE.
- Beats with `mem_rvalid=1` while not in FILL are not consumed, because `mem_rready=0`.

## Timing
- Reset values: state IDLE, `cnt=0`, `req_ready=1`, `mem_rready=0`, `Data_we=0`, `done_valid=0`, `err=0`, line buffer 0, `Data_addr_write=0`, `Data_din_write=0`.
- Reset asserted in any state returns the engine to IDLE on the next edge.
  - No partial-line write occurs.
  - A beat presented in the reset cycle is not accepted.
- Best case: request accepted at cycle T, beats at T+1..T+BEATS, write at T+BEATS+1, and `req_ready` again at T+BEATS+2.
- Gaps in `mem_rvalid` stall FILL indefinitely with `cnt` held.
- A request presented during FILL or WRITE is held off by `req_ready=0`. It is never dropped, and it is accepted in the first IDLE cycle.
- All outputs are registered or decoded from state only; there is no combinational path from `mem_*` or `req_*` to any output.

## Structure
- Shared package `icache_pkg` holds:
  - the state encoding (IDLE=2'd0, FILL=2'd1, WRITE=2'd2);
  - the BEATS and counter-width derivation;
  - the way one-hot decode function.
- One sub-module, `refill_line_buf`, is natural. It is the BEATS-slot beat assembler with a write-slot index and clear input, outputting the full line.
- The FSM and handshake logic stay in the top module.

## Test plan
- Basic refill:
  - Stimulus: `req_index=4'h5`, `req_way=1`, then beats 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444 (`mem_rlast` on the 4th) on consecutive cycles.
  - Response: exactly one cycle with `Data_we=2'b10`, `Data_addr_write=5`, `Data_din_write=128'h44444444_33333333_22222222_11111111`, and `done_valid=1`.
- Stalled burst:
  - Stimulus: same request on way 0, with `mem_rvalid` dropped for 3 cycles between beats 1 and 2.
  - Response: the same line is written, `Data_we=2'b01`, and no extra beats are consumed.
- Early last:
  - Stimulus: `mem_rlast=1` on beat 2.
  - Response: `err` pulses for 1 cycle, `Data_we` stays 0, `done_valid` stays 0, and `req_ready=1` on the next cycle.
- Missing last:
  - Stimulus: 4 beats with `mem_rlast=0` throughout.
  - Response: the line is written and `err` and `done_valid` both pulse in the same cycle.
- Reset mid-FILL:
  - Stimulus: assert `rstn` after beat 1, then issue a fresh request with 4 new beats.
  - Response: no write occurs during or after reset, and the new line contains only new beats.
- Back-to-back requests:
  - Stimulus: `req_valid` is held high with a second index.
  - Response: the second handshake occurs 1 cycle after the first WRITE, and the two writes target the correct indices.
